cmul_arbiter: RTL and testbench

Round-robin arbiter that shares one `complex_multiplier` instance among `N_REQ` requesters, such as several mean-square accumulators or a correlator. Each requester presents a packed complex operand pair and holds a level request. The arbiter latches the winner's operands, sequences the multiplier's start/done handshake, and returns the 2×WIDTH product with a per-requester acknowledge. A watchdog aborts a transaction whose `done` never arrives.

---
 rtl/cmul_arbiter_if.sv | 33 +++
 rtl/cmul_arbiter.sv | 129 ++++++++++++
 tb/tb_cmul_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmul_arbiter_if.sv
// rtl/cmul_arbiter_if.sv - requester, result and multiplier signals of the shared complex-multiplier arbiter
// slave is the arbiter side; master is the requesters plus the multiplier.
interface cmul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       ack;
  logic [2*WIDTH-1:0]     result;
  logic                   result_valid;
  logic                   error;
  logic [GW-1:0]          grant_id;
  logic                   busy;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_result;

  modport slave (
    input  req, req_a, req_b, mul_done, mul_result,
    output ack, result, result_valid, error, grant_id, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, req_a, req_b, mul_done, mul_result,
    input  ack, result, result_valid, error, grant_id, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/cmul_arbiter.sv
// rtl/cmul_arbiter.sv - round-robin arbiter sharing one complex multiplier among N_REQ requesters
// Sequences the multiplier start/done handshake and aborts a transaction after TIMEOUT busy cycles.
module cmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  cmul_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      win_id;
  logic               win_found;
  logic [GW-1:0]      ptr_nxt;
  logic [CW-1:0]      wd_cnt;
  logic               done_hit;
  logic               timeout_hit;

  logic [N_REQ-1:0]   ack_q;
  logic [2*WIDTH-1:0] result_q;
  logic               result_valid_q;
  logic               error_q;
  logic [GW-1:0]      grant_q;
  logic               mul_start_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;

  // First requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
      end
    end
  end

  assign ptr_nxt     = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign done_hit    = (state == BUSY) && bus.mul_done;
  // Completion takes priority when done arrives on the last watchdog cycle.
  assign timeout_hit = (state == BUSY) && !bus.mul_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_found) state_nxt = BUSY;
      BUSY:    if (done_hit || timeout_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      wd_cnt         <= '0;
      ack_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      grant_q        <= '0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q     <= win_id;
            mul_a_q     <= bus.req_a[int'(win_id)*WIDTH +: WIDTH];
            mul_b_q     <= bus.req_b[int'(win_id)*WIDTH +: WIDTH];
            mul_start_q <= 1'b1;
            wd_cnt      <= '0;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (done_hit) begin
            result_q       <= bus.mul_result;
            result_valid_q <= 1'b1;
            ack_q          <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
            mul_start_q    <= 1'b0;
            rr_ptr         <= ptr_nxt;
          end else if (timeout_hit) begin
            error_q     <= 1'b1;
            ack_q       <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
            mul_start_q <= 1'b0;
            rr_ptr      <= ptr_nxt;
          end
        end
        RELEASE: begin
          ack_q          <= '0;
          result_valid_q <= 1'b0;
          error_q        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack          = ack_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state != IDLE);
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
endmodule

// File: tb/tb_cmul_arbiter.sv
// tb/tb_cmul_arbiter.sv - directed self-checking bench for cmul_arbiter with a behavioural multiplier
module tb_cmul_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cmul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  cmul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] cmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] re, im;
    ar = a[31:16]; ai = a[15:0];
    br = b[31:16]; bi = b[15:0];
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re, im};
  endfunction

  // Multiplier model: done pulses mdl_lat cycles after start rises, unless disabled.
  bit mdl_en  = 1'b1;
  int mdl_lat = 5;
  int mdl_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mul_done   <= 1'b0;
      bus.mul_result <= '0;
      mdl_cnt        <= 0;
    end else if (bus.mul_start && !bus.mul_done && mdl_en) begin
      if (mdl_cnt == mdl_lat - 1) begin
        bus.mul_done   <= 1'b1;
        bus.mul_result <= cmul(bus.mul_a, bus.mul_b);
        mdl_cnt        <= 0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end else begin
      bus.mul_done <= 1'b0;
      if (!bus.mul_start) mdl_cnt <= 0;
    end
  end

  int start_rises;
  int low_run;
  int min_low;
  logic start_d;
  always @(posedge clk) begin
    if (reset) begin
      start_rises = 0;
      low_run     = 0;
      min_low     = 1000;
      start_d     = 1'b0;
    end else begin
      if (bus.mul_start && !start_d) begin
        start_rises++;
        if (low_run < min_low) min_low = low_run;
      end
      low_run = bus.mul_start ? 0 : low_run + 1;
      start_d = bus.mul_start;
    end
  end

  task automatic wait_ack(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < max);
    check("ack_seen", 64'(bus.ack != '0), 64'(1));
  endtask

  task automatic wait_start(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mul_start && n < max);
    check("start_seen", 64'(bus.mul_start), 64'(1));
  endtask

  initial begin
    logic [63:0] exp2 [4];
    int n;
    int g;
    exp2[0] = 64'hFFFFFFFB_0000000A;
    exp2[1] = 64'h00000000_0000000A;
    exp2[2] = 64'hFFFFFFF9_FFFFFFFD;
    exp2[3] = 64'h3FFF0001_00000000;

    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_ack",       64'(bus.ack),          64'(0));
    check("rst_busy",      64'(bus.busy),         64'(0));
    check("rst_start",     64'(bus.mul_start),    64'(0));
    check("rst_result",    bus.result,            64'(0));
    check("rst_valid",     64'(bus.result_valid), 64'(0));
    check("rst_error",     64'(bus.error),        64'(0));
    check("rst_grant",     64'(bus.grant_id),     64'(0));
    reset = 1'b0;

    // Single request from requester 1: (3+4j)^2 = -7+24j
    bus.req_a[1*W +: W] = 32'h0003_0004;
    bus.req_b[1*W +: W] = 32'h0003_0004;
    bus.req = 4'b0010;
    wait_start(20);
    check("t1_grant",  64'(bus.grant_id), 64'(1));
    check("t1_busy",   64'(bus.busy),     64'(1));
    check("t1_mul_a",  64'(bus.mul_a),    64'h0003_0004);
    wait_ack(100, n);
    check("t1_latency", 64'(n),                64'(6));
    check("t1_ack",     64'(bus.ack),          64'(4'b0010));
    check("t1_result",  bus.result,            64'hFFFFFFF9_00000018);
    check("t1_valid",   64'(bus.result_valid), 64'(1));
    check("t1_error",   64'(bus.error),        64'(0));
    bus.req = 4'b0000;
    @(negedge clk);
    check("t1_ack_clr",   64'(bus.ack),          64'(0));
    check("t1_valid_clr", 64'(bus.result_valid), 64'(0));
    check("t1_busy_clr",  64'(bus.busy),         64'(0));
    repeat (3) @(negedge clk);
    check("t1_one_start", 64'(start_rises), 64'(1));

    // All four requesters from reset
    bus.req_a[0*W +: W] = 32'h0001_0002; bus.req_b[0*W +: W] = 32'h0003_0004;
    bus.req_a[1*W +: W] = 32'h0002_0000; bus.req_b[1*W +: W] = 32'h0000_0005;
    bus.req_a[2*W +: W] = 32'hFFFF_0000; bus.req_b[2*W +: W] = 32'h0007_0003;
    bus.req_a[3*W +: W] = 32'h7FFF_0000; bus.req_b[3*W +: W] = 32'h7FFF_0000;
    bus.req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(100, n);
      check($sformatf("t2_grant%0d", i),  64'(bus.grant_id), 64'(i));
      check($sformatf("t2_ack%0d", i),    64'(bus.ack),      64'(1) << i);
      check($sformatf("t2_result%0d", i), bus.result,        exp2[i]);
      bus.req[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("t2_starts",    64'(start_rises),  64'(4));
    check("t2_start_gap", 64'(min_low >= 1), 64'(1));

    // Fairness: requesters 0 and 2 held continuously
    bus.req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 0) ? 0 : 2;
      wait_ack(100, n);
      check($sformatf("t3_grant%0d", i), 64'(bus.grant_id), 64'(g));
      check($sformatf("t3_ack%0d", i),   64'(bus.ack),      64'(1) << g);
    end
    bus.req = 4'b0000;

    // Timeout: multiplier never answers
    mdl_en  = 1'b0;
    bus.req = 4'b0010;
    wait_start(20);
    check("t4_grant", 64'(bus.grant_id), 64'(1));
    wait_ack(200, n);
    check("t4_cycles", 64'(n),                64'(64));
    check("t4_ack",    64'(bus.ack),          64'(4'b0010));
    check("t4_error",  64'(bus.error),        64'(1));
    check("t4_valid",  64'(bus.result_valid), 64'(0));
    check("t4_result", bus.result,            64'hFFFFFFF9_FFFFFFFD);
    check("t4_start",  64'(bus.mul_start),    64'(0));
    bus.req = 4'b0000;
    mdl_en  = 1'b1;
    @(negedge clk);
    check("t4_error_clr", 64'(bus.error), 64'(0));
    bus.req = 4'b1000;
    wait_ack(100, n);
    check("t4_next_ack",    64'(bus.ack),          64'(4'b1000));
    check("t4_next_valid",  64'(bus.result_valid), 64'(1));
    check("t4_next_error",  64'(bus.error),        64'(0));
    check("t4_next_result", bus.result,            64'h3FFF0001_00000000);
    bus.req = 4'b0000;

    // Reset while requester 2 is in BUSY
    bus.req = 4'b0100;
    wait_start(20);
    check("t5_grant", 64'(bus.grant_id), 64'(2));
    repeat (3) @(negedge clk);
    reset   = 1'b1;
    bus.req = 4'b0101;
    #1;
    check("t5_start", 64'(bus.mul_start), 64'(0));
    check("t5_busy",  64'(bus.busy),      64'(0));
    check("t5_ack",   64'(bus.ack),       64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ack(100, n);
    check("t5_ack_first",   64'(bus.ack),      64'(4'b0001));
    check("t5_grant_first", 64'(bus.grant_id), 64'(0));
    bus.req = 4'b0000;

    // Operand stability and done on the timeout cycle
    mdl_lat = 63;
    bus.req_a[1*W +: W] = 32'h0003_0004;
    bus.req_b[1*W +: W] = 32'h0003_0004;
    bus.req = 4'b0010;
    wait_start(20);
    check("t6_mul_a", 64'(bus.mul_a), 64'h0003_0004);
    bus.req_a[1*W +: W] = 32'h1234_5678;
    @(negedge clk);
    check("t6_mul_a_hold", 64'(bus.mul_a), 64'h0003_0004);
    wait_ack(200, n);
    check("t6_cycles", 64'(n + 1),            64'(64));
    check("t6_ack",    64'(bus.ack),          64'(4'b0010));
    check("t6_valid",  64'(bus.result_valid), 64'(1));
    check("t6_error",  64'(bus.error),        64'(0));
    check("t6_result", bus.result,            64'hFFFFFFF9_00000018);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish by 100000");
    $fatal(1, "simulation time limit reached");
  end
endmodule
